// File: rtl/hop_kernel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hop_kernel_pkg
// Description : Shared constants, types and helpers for the hop-selection
//               kernel: channel count, AFH minimum, datapath widths, FSM
//               state type, the bank-order position-to-channel mapping and
//               the combinational mod-79 reduction.
// Revision    : 1.0 - initial release
// ============================================================================
package hop_kernel_pkg;

    localparam int NUM_CHAN  = 79;
    localparam int AFH_NMIN  = 20;

    localparam int CHAN_W    = 7;
    localparam int K_W       = 7;
    localparam int SUM_W     = 9;

    typedef logic [CHAN_W-1:0] chan_t;
    typedef logic [K_W-1:0]    k_t;
    typedef logic [SUM_W-1:0]  sum_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PERM = 3'd1,
        ADD  = 3'd2,
        MODN = 3'd3,
        SCAN = 3'd4,
        DONE = 3'd5
    } state_t;

    // Register-bank order: positions 0..39 are the even channels 0..78,
    // positions 40..78 are the odd channels 1..77. The same mapping turns
    // the basic-hop index k into its channel.
    function automatic chan_t bank_order(input k_t pos);
        k_t t;
        if (pos < k_t'(40)) begin
            return {pos[5:0], 1'b0};
        end
        t = pos - k_t'(40);
        return {t[5:0], 1'b1};
    endfunction

    // Compare/subtract chain. Four stages cover every value the 9-bit
    // sum of the kernel inputs can take (max 348), not only the nominal
    // 268 of a well-formed control word.
    function automatic k_t mod79(input sum_t s);
        sum_t r;
        r = s;
        for (int i = 0; i < 4; i++) begin
            if (r >= sum_t'(NUM_CHAN)) begin
                r = r - sum_t'(NUM_CHAN);
            end
        end
        return r[K_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/hop_kernel_if.sv
`default_nettype none
// ============================================================================
// Module      : hop_kernel_if
// Description : Request/response bundle between the link controller
//               (master) and the hop-selection kernel (slave).
//               master drives: start_p, X, Y1, Y2, A..F, Fprime,
//                              afh_en, afh_map, afh_N
//               slave drives : chan, chan_valid_p, busy, remap_err
// Revision    : 1.0 - initial release
// ============================================================================
interface hop_kernel_if;
    import hop_kernel_pkg::*;

    logic        start_p;
    logic [4:0]  X;
    logic        Y1;
    logic [5:0]  Y2;
    logic [4:0]  A;
    logic [3:0]  B;
    logic [4:0]  C;
    logic [8:0]  D;
    logic [6:0]  E;
    logic [6:0]  F;
    logic [6:0]  Fprime;
    logic        afh_en;
    logic [78:0] afh_map;
    logic [6:0]  afh_N;

    chan_t       chan;
    logic        chan_valid_p;
    logic        busy;
    logic        remap_err;

    modport master (
        output start_p, X, Y1, Y2, A, B, C, D, E, F, Fprime,
               afh_en, afh_map, afh_N,
        input  chan, chan_valid_p, busy, remap_err
    );

    modport slave (
        input  start_p, X, Y1, Y2, A, B, C, D, E, F, Fprime,
               afh_en, afh_map, afh_N,
        output chan, chan_valid_p, busy, remap_err
    );

endinterface
`default_nettype wire

// File: rtl/hop_kernel_perm5.sv
`default_nettype none
// ============================================================================
// Module      : hop_perm5
// Description : Purely combinational 5-bit, 7-stage butterfly permutation
//               driven by 14 control bits. Each control bit, when set,
//               swaps one pair of bits; the two pairs in a stage are
//               disjoint so their order within a stage is irrelevant.
//   i_z    [4:0]  value to permute
//   i_p    [13:0] control word (P13 acts first)
//   o_perm [4:0]  permuted value
// Revision    : 1.0 - initial release
// ============================================================================
module hop_perm5 (
    input  wire logic [4:0]  i_z,
    input  wire logic [13:0] i_p,
    output logic      [4:0]  o_perm
);

    function automatic logic [4:0] swap2(
        input logic [4:0] v,
        input logic [2:0] a,
        input logic [2:0] b,
        input logic       en
    );
        logic [4:0] r;
        r = v;
        if (en) begin
            r[a] = v[b];
            r[b] = v[a];
        end
        return r;
    endfunction

    always_comb begin
        logic [4:0] w_v;
        w_v = i_z;
        // stage 1
        w_v = swap2(w_v, 3'd0, 3'd1, i_p[13]);
        w_v = swap2(w_v, 3'd2, 3'd3, i_p[12]);
        // stage 2
        w_v = swap2(w_v, 3'd1, 3'd2, i_p[11]);
        w_v = swap2(w_v, 3'd3, 3'd4, i_p[10]);
        // stage 3
        w_v = swap2(w_v, 3'd0, 3'd4, i_p[9]);
        w_v = swap2(w_v, 3'd1, 3'd3, i_p[8]);
        // stage 4
        w_v = swap2(w_v, 3'd0, 3'd3, i_p[7]);
        w_v = swap2(w_v, 3'd2, 3'd4, i_p[6]);
        // stage 5
        w_v = swap2(w_v, 3'd1, 3'd3, i_p[5]);
        w_v = swap2(w_v, 3'd0, 3'd2, i_p[4]);
        // stage 6
        w_v = swap2(w_v, 3'd3, 3'd4, i_p[3]);
        w_v = swap2(w_v, 3'd1, 3'd2, i_p[2]);
        // stage 7
        w_v = swap2(w_v, 3'd0, 3'd2, i_p[1]);
        w_v = swap2(w_v, 3'd1, 3'd3, i_p[0]);
        o_perm = w_v;
    end

endmodule
`default_nettype wire

// File: rtl/hop_kernel.sv
`default_nettype none
// ============================================================================
// Module      : hop_kernel
// Description : Hop-selection kernel. Captures a hopping control word on
//               start_p, computes the basic-hop channel (adder 1, PERM5
//               butterfly, adder 2 mod 79, bank mapping) and, when AFH is
//               enabled and the basic channel is unused, remaps it through
//               an iterative mod-N and a used-channel scan.
//   clk_6M  6 MHz clock
//   rst     synchronous active-high reset
//   bus     hop_kernel_if.slave: request inputs, chan / chan_valid_p /
//           busy / remap_err outputs
// Revision    : 1.0 - initial release
// ============================================================================
module hop_kernel
    import hop_kernel_pkg::*;
(
    input  wire logic   clk_6M,
    input  wire logic   rst,
    hop_kernel_if.slave bus
);

    localparam k_t c_NMIN     = k_t'(AFH_NMIN);
    localparam k_t c_NMAX     = k_t'(NUM_CHAN);
    localparam k_t c_LAST_POS = k_t'(NUM_CHAN - 1);

    state_t      r_state;
    state_t      w_state_next;

    // captured request
    logic [4:0]  r_x;
    logic        r_y1;
    logic [5:0]  r_y2;
    logic [4:0]  r_a;
    logic [3:0]  r_b;
    logic [4:0]  r_c;
    logic [8:0]  r_d;
    logic [6:0]  r_e;
    logic [6:0]  r_f_in;
    logic [6:0]  r_fp;
    logic        r_afh_en;
    logic [78:0] r_map;
    k_t          r_n;

    // working registers
    logic [4:0]  r_perm;
    chan_t       r_fch;
    sum_t        r_sumn;
    k_t          r_pos;
    k_t          r_cnt;
    chan_t       r_chan;
    logic        r_err;

    logic [4:0]  w_xa;
    logic [4:0]  w_z;
    logic [13:0] w_p;
    logic [4:0]  w_perm;
    sum_t        w_sum_f;
    sum_t        w_sum_fp;
    chan_t       w_f;
    logic        w_remap;
    logic        w_n_bad;
    sum_t        w_n_ext;
    logic        w_ge;
    sum_t        w_sub;
    chan_t       w_scan_ch;
    logic        w_used;
    logic        w_hit;
    logic        w_last;
    logic        w_busy;
    logic        w_valid;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    assign w_xa = r_x + r_a;                       // mod 32 by width
    assign w_z  = {w_xa[4], w_xa[3:0] ^ r_b};
    assign w_p  = {r_d, r_c ^ {5{r_y1}}};

    hop_perm5 u_perm5 (
        .i_z    (w_z),
        .i_p    (w_p),
        .o_perm (w_perm)
    );

    assign w_sum_f  = {4'd0, r_perm} + {2'd0, r_e} + {2'd0, r_f_in} + {3'd0, r_y2};
    assign w_sum_fp = {4'd0, r_perm} + {2'd0, r_e} + {2'd0, r_fp}   + {3'd0, r_y2};
    assign w_f      = bank_order(mod79(w_sum_f));

    assign w_remap  = r_afh_en && !r_map[w_f];
    assign w_n_bad  = (r_n < c_NMIN) || (r_n > c_NMAX);

    assign w_n_ext  = {2'd0, r_n};
    assign w_ge     = (r_sumn >= w_n_ext);
    assign w_sub    = r_sumn - w_n_ext;

    // After MODN, r_sumn holds k' (< afh_N <= 79), so it is compared
    // against the running count of used channels seen so far.
    assign w_scan_ch = bank_order(r_pos);
    assign w_used    = r_map[w_scan_ch];
    assign w_hit     = w_used && ({2'd0, r_cnt} == r_sumn);
    assign w_last    = (r_pos == c_LAST_POS);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_6M) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (bus.start_p) w_state_next = PERM;
            PERM: w_state_next = ADD;
            ADD:  w_state_next = (!w_remap || w_n_bad) ? DONE : MODN;
            // Leave as soon as the remainder is known: either no
            // subtraction is possible, or this cycle's subtraction
            // lands below afh_N.
            MODN: if (!w_ge || (w_sub < w_n_ext)) w_state_next = SCAN;
            SCAN: if (w_hit || w_last) w_state_next = DONE;
            DONE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_busy  = (r_state != IDLE);
        w_valid = (r_state == DONE);
    end

    assign bus.chan         = r_chan;
    assign bus.chan_valid_p = w_valid;
    assign bus.busy         = w_busy;
    assign bus.remap_err    = r_err;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_6M) begin
        if (rst) begin
            r_x      <= '0;
            r_y1     <= 1'b0;
            r_y2     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_d      <= '0;
            r_e      <= '0;
            r_f_in   <= '0;
            r_fp     <= '0;
            r_afh_en <= 1'b0;
            r_map    <= '0;
            r_n      <= '0;
            r_perm   <= '0;
            r_fch    <= '0;
            r_sumn   <= '0;
            r_pos    <= '0;
            r_cnt    <= '0;
            r_chan   <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start_p) begin
                        r_x      <= bus.X;
                        r_y1     <= bus.Y1;
                        r_y2     <= bus.Y2;
                        r_a      <= bus.A;
                        r_b      <= bus.B;
                        r_c      <= bus.C;
                        r_d      <= bus.D;
                        r_e      <= bus.E;
                        r_f_in   <= bus.F;
                        r_fp     <= bus.Fprime;
                        r_afh_en <= bus.afh_en;
                        r_map    <= bus.afh_map;
                        r_n      <= bus.afh_N;
                        r_err    <= 1'b0;
                    end
                end
                PERM: begin
                    r_perm <= w_perm;
                end
                ADD: begin
                    r_fch  <= w_f;
                    r_sumn <= w_sum_fp;
                    r_pos  <= '0;
                    r_cnt  <= '0;
                    // Channel is final here unless the remap will run.
                    if (!w_remap) begin
                        r_chan <= w_f;
                    end else if (w_n_bad) begin
                        r_chan <= w_f;
                        r_err  <= 1'b1;
                    end
                end
                MODN: begin
                    if (w_ge) begin
                        r_sumn <= w_sub;
                    end
                end
                SCAN: begin
                    r_pos <= r_pos + k_t'(1);
                    if (w_used) begin
                        r_cnt <= r_cnt + k_t'(1);
                    end
                    if (w_hit) begin
                        r_chan <= w_scan_ch;
                    end else if (w_last) begin
                        // afh_N exceeded the number of used channels
                        r_chan <= r_fch;
                        r_err  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hop_kernel.sv
`default_nettype none
// ============================================================================
// Module      : tb_hop_kernel
// Description : Self-checking bench for hop_kernel. Stimulus pushes the
//               expected channel, error flag and latency into a queue; a
//               monitor pops and compares on every chan_valid_p and checks
//               busy every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hop_kernel;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hop_kernel_if bus ();

    hop_kernel dut (
        .clk_6M (clk),
        .rst    (rst),
        .bus    (bus)
    );

    typedef struct {
        logic [4:0]  x;
        logic        y1;
        logic [4:0]  a;
        logic [3:0]  b;
        logic [4:0]  c;
        logic [8:0]  d;
        logic [6:0]  e;
        logic [6:0]  f;
        logic [6:0]  fp;
        logic        en;
        logic [78:0] map;
        logic [6:0]  n;
    } stim_t;

    typedef struct {
        int chan;
        int err;
        int lat;
        int t0;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks    = 0;
    int   n_fail      = 0;
    int   ncyc        = 0;
    bit   busy_chk_en = 1'b0;

    // Butterfly pair for control bit Pj: swaps Z bits sw_a[j] and sw_b[j].
    int sw_a [0:13] = '{1, 0, 1, 3, 0, 1, 2, 0, 1, 0, 3, 1, 2, 0};
    int sw_b [0:13] = '{3, 2, 2, 4, 2, 3, 4, 3, 3, 4, 4, 2, 3, 1};

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------
    function automatic int bank_ch(input int pos);
        return (pos < 40) ? 2 * pos : 2 * (pos - 40) + 1;
    endfunction

    function automatic int bank_pos(input int ch);
        return (ch % 2 == 0) ? ch / 2 : 40 + ch / 2;
    endfunction

    function automatic int perm_model(input stim_t s);
        int z, p, t, r;
        int zb[5];
        z = (int'(s.x) + int'(s.a)) % 32;
        z = (z & 16) | ((z & 15) ^ int'(s.b));
        p = (int'(s.d) << 5) | (int'(s.c) ^ (s.y1 ? 31 : 0));
        for (int i = 0; i < 5; i++) zb[i] = (z >> i) & 1;
        for (int j = 13; j >= 0; j--) begin
            if (((p >> j) & 1) == 1) begin
                t = zb[sw_a[j]];
                zb[sw_a[j]] = zb[sw_b[j]];
                zb[sw_b[j]] = t;
            end
        end
        r = 0;
        for (int i = 0; i < 5; i++) r = r | (zb[i] << i);
        return r;
    endfunction

    function automatic exp_t model(input stim_t s);
        exp_t r;
        int perm, y2, f, sfp, kp, q, m, n, ch;
        int used[$];
        perm = perm_model(s);
        y2   = s.y1 ? 32 : 0;
        f    = bank_ch((perm + int'(s.e) + int'(s.f) + y2) % 79);
        n    = int'(s.n);
        r.chan = f;
        r.err  = 0;
        r.lat  = 3;
        r.t0   = 0;
        if (s.en && !s.map[f]) begin
            if (n < 20 || n > 79) begin
                r.err = 1;
            end else begin
                sfp = perm + int'(s.e) + int'(s.fp) + y2;
                kp  = sfp % n;
                q   = sfp / n;
                m   = (q < 1) ? 1 : q;
                for (int pos = 0; pos < 79; pos++)
                    if (s.map[bank_ch(pos)]) used.push_back(bank_ch(pos));
                if (kp < used.size()) begin
                    ch     = used[kp];
                    r.chan = ch;
                    r.lat  = 3 + m + bank_pos(ch) + 1;
                end else begin
                    r.err = 1;
                    r.lat = 3 + m + 79;
                end
            end
        end
        return r;
    endfunction

    // ---------------------------------------------------------------
    // Monitor
    // ---------------------------------------------------------------
    initial begin
        exp_t e;
        bit   eb;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst) begin
                if (busy_chk_en) begin
                    eb = (exp_q.size() > 0) && (ncyc > exp_q[0].t0);
                    chk("busy", int'(bus.busy), int'(eb));
                end
                if (bus.chan_valid_p) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", int'(bus.chan_valid_p), 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("chan", int'(bus.chan), e.chan);
                        chk("remap_err", int'(bus.remap_err), e.err);
                        chk("latency", ncyc - e.t0, e.lat);
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------
    function automatic stim_t zero_stim();
        stim_t s;
        s.x = '0; s.y1 = 1'b0; s.a = '0; s.b = '0; s.c = '0; s.d = '0;
        s.e = '0; s.f = '0; s.fp = '0; s.en = 1'b0; s.map = '0; s.n = '0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        int dens;
        s.x   = 5'($urandom);
        s.y1  = 1'($urandom);
        s.a   = 5'($urandom);
        s.b   = 4'($urandom);
        s.c   = 5'($urandom);
        s.d   = 9'($urandom);
        s.e   = 7'($urandom);
        s.f   = 7'($urandom);
        s.fp  = 7'($urandom);
        s.en  = ($urandom_range(0, 3) != 0);
        dens  = $urandom_range(20, 90);
        for (int i = 0; i < 79; i++) s.map[i] = ($urandom_range(0, 99) < dens);
        s.n   = 7'($urandom_range(14, 82));
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bus.X       = s.x;
        bus.Y1      = s.y1;
        bus.Y2      = s.y1 ? 6'd32 : 6'd0;
        bus.A       = s.a;
        bus.B       = s.b;
        bus.C       = s.c;
        bus.D       = s.d;
        bus.E       = s.e;
        bus.F       = s.f;
        bus.Fprime  = s.fp;
        bus.afh_en  = s.en;
        bus.afh_map = s.map;
        bus.afh_N   = s.n;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            chk("timeout_pending", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // start_p stays high for 'hold' cycles; inputs are scrambled after the
    // accepting edge so only the captured request may matter.
    task automatic run_txn(input stim_t s, input int hold);
        exp_t e;
        @(posedge clk);
        #1;
        drive(s);
        bus.start_p = 1'b1;
        e    = model(s);
        e.t0 = ncyc + 1;
        exp_q.push_back(e);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            drive(rand_stim());
        end
        bus.start_p = 1'b0;
        wait_empty();
    endtask

    // ---------------------------------------------------------------
    // Main sequence
    // ---------------------------------------------------------------
    initial begin
        stim_t s;
        stim_t rmap;
        bus.start_p = 1'b0;
        drive(zero_stim());
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_chan",      int'(bus.chan), 0);
        chk("reset_valid",     int'(bus.chan_valid_p), 0);
        chk("reset_busy",      int'(bus.busy), 0);
        chk("reset_remap_err", int'(bus.remap_err), 0);
        busy_chk_en = 1'b1;

        // all zero
        run_txn(zero_stim(), 1);
        // only P13 set
        s = zero_stim(); s.x = 5'd1; s.d = 9'h100;
        run_txn(s, 1);
        // E = 100 -> k = 22
        s = zero_stim(); s.x = 5'd1; s.e = 7'd100;
        run_txn(s, 1);
        // Y1 = 1 -> k = 40
        s = zero_stim(); s.x = 5'd1; s.y1 = 1'b1;
        run_txn(s, 1);

        // AFH with channels 10..29 used
        rmap = zero_stim();
        rmap.en = 1'b1;
        for (int i = 10; i <= 29; i++) rmap.map[i] = 1'b1;
        rmap.n = 7'd20;
        run_txn(rmap, 1);
        s = rmap; s.e = 7'd25;
        run_txn(s, 1);
        // afh_N below the minimum
        s = rmap; s.e = 7'd25; s.n = 7'd15;
        run_txn(s, 1);
        // afh_N above the maximum
        s = rmap; s.e = 7'd25; s.n = 7'd80;
        run_txn(s, 1);
        // afh_N exceeds the 20 used channels; k' = 25 never found
        s = rmap; s.fp = 7'd25; s.n = 7'd30;
        run_txn(s, 1);
        // leave a non-zero channel behind before the reset test
        s = rmap; s.e = 7'd25;
        run_txn(s, 1);

        // start_p held through the DONE cycle: exactly one response
        s = zero_stim(); s.x = 5'd3; s.e = 7'd7;
        run_txn(s, 4);
        repeat (8) @(posedge clk);

        // reset while scanning: odd channels used, k' = 0 -> hit at pos 40
        busy_chk_en = 1'b0;
        s = zero_stim();
        s.en = 1'b1;
        for (int i = 1; i < 79; i += 2) s.map[i] = 1'b1;
        s.n = 7'd39;
        @(posedge clk);
        #1;
        drive(s);
        bus.start_p = 1'b1;
        @(posedge clk);
        #1;
        bus.start_p = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_chan",  int'(bus.chan), 0);
        chk("midrst_busy",  int'(bus.busy), 0);
        chk("midrst_valid", int'(bus.chan_valid_p), 0);
        chk("midrst_err",   int'(bus.remap_err), 0);
        busy_chk_en = 1'b1;
        repeat (60) @(posedge clk);

        // recovery after reset
        run_txn(rmap, 1);

        // randomized requests
        for (int t = 0; t < 150; t++) begin
            run_txn(rand_stim(), $urandom_range(1, 3));
        end

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/hop_kernel.md
# hop_kernel

Hop-selection kernel that consumes the hopping control word (X, Y1, Y2, A–F, F′) and produces the RF channel index 0..78 (Core 5.1 Vol 2 Part B 2.6.3). It sits downstream of the control-word generator: the link controller pulses `start_p` once per slot or half-slot, and the kernel returns the channel with a one-cycle valid pulse. It includes the AFH remapping path (used-channel map, N-modulus), implemented as a multi-cycle FSM.

## Interface
- No parameters. Constants are in the shared package.
- clk_6M  in  1  6 MHz system clock
- rst  in  1  synchronous, active-high reset
- start_p  in  1  one-cycle request; accepted only when idle
- X  in  5  phase input
- Y1  in  1  master/slave TX select
- Y2  in  6  Y1×32
- A  in  5  address-derived input
- B  in  4  address-derived input
- C  in  5  address-derived input
- D  in  9  address-derived input
- E  in  7  address-derived input
- F  in  7  basic-hop offset
- Fprime  in  7  AFH offset
- afh_en  in  1  enable AFH remap
- afh_map  in  79  bit n = 1 means channel n is used
- afh_N  in  7  number of used channels
- chan  out  7  selected channel; holds its value between requests
- chan_valid_p  out  1  one-cycle pulse when `chan` updates
- busy  out  1  high from the cycle after acceptance through the cycle of the valid pulse
- remap_err  out  1  set with `chan_valid_p` when the remap fails; cleared on the next acceptance

## Operation
- Capture: on `start_p` in IDLE, register all inputs, including `afh_map` and `afh_N`. Later input changes have no effect on the request in flight. `start_p` while busy is ignored; no queueing.
- Adder 1: Z = ((X + A) mod 32) with bits [3:0] XOR B.
- PERM5 control: P[4:0] = C XOR {5{Y1}}, P[13:5] = D. The butterfly has 7 stages; each bit swaps the listed Z-bit pair when it is 1:
  - stage 1: P13 (0,1), P12 (2,3)
  - stage 2: P11 (1,2), P10 (3,4)
  - stage 3: P9 (0,4), P8 (1,3)
  - stage 4: P7 (0,3), P6 (2,4)
  - stage 5: P5 (1,3), P4 (0,2)
  - stage 6: P3 (3,4), P2 (1,2)
  - stage 7: P1 (0,2), P0 (1,3)
- Adder 2: k = (perm + E + F + Y2) mod 79. The sum is at most 268 and fits in 9 bits. Reduce with a combinational compare/subtract chain of up to 3 subtractions.
- Register-bank map: k < 40 → channel 2k; otherwise channel 2(k−40)+1.
- AFH: if `afh_en` = 1 and `afh_map[f]` = 0, remap:
  - k′ = (perm + E + Fprime + Y2) mod afh_N, by iterative subtraction, one subtraction per cycle.
  - Scan the bank order 0,2,…,78,1,3,…,77, one channel per cycle, counting used channels.
  - Output the k′-th used channel (0-based).
- FSM states:
  - IDLE → PERM on accepted start.
  - PERM: register perm.
  - ADD: register f and sumN. Go to DONE if no remap is needed, else MODN.
  - MODN: subtract afh_N while sumN ≥ afh_N, then go to SCAN.
  - SCAN: step through the bank order; DONE on a hit.
  - DONE: update `chan`, pulse `chan_valid_p`, return to IDLE.
- Remap boundaries:
  - If afh_N < 20 or afh_N > 79: skip MODN/SCAN, output unmapped f, set remap_err = 1.
  - If all 79 positions are scanned with no hit (afh_N exceeds the map popcount): output f, set remap_err = 1.

## Timing
- Reset values: chan = 0, chan_valid_p = 0, busy = 0, remap_err = 0, state = IDLE.
- Start sampled in cycle T0. Non-remap path: `chan_valid_p` in T3, busy high T1–T3.
- Remap path: latency = 3 + (MODN iterations, ≤ 13, at least 1 cycle) + (scan position + 1, ≤ 79). Worst case ≤ 96 cycles, well inside the 3750-cycle slot.
- A `start_p` in the same cycle as the DONE pulse is ignored; the next accept is possible the cycle after.
- `rst` mid-operation: return to IDLE next cycle, outputs go to their reset values, and no valid pulse is produced.

## Structure
- Shared package holds:
  - NUM_CHAN = 79, AFH_NMIN = 20.
  - Channel, k, and sum widths (7/7/9).
  - FSM state enum {IDLE, PERM, ADD, MODN, SCAN, DONE}.
  - A bank-order function mapping position → channel.
- One sub-module is natural: `hop_perm5`, the purely combinational 5-bit, 14-control butterfly.

## Test plan
- All inputs 0, afh_en = 0 → chan = 0, pulse at T3, busy high T1–T3.
- X = 1, D = 9'h100 (only P13 set), rest 0 → perm = 2, chan = 4. With E = 100 instead of D set: X = 1 gives perm = 1, k = 101 mod 79 = 22, chan = 44.
- X = 1, Y1 = 1, Y2 = 32, C = 0, D = 0 → perm = 8, k = 40, chan = 1.
- afh_en = 1, map = channels 10..29 used, afh_N = 20, all inputs 0 → f = 0 unused → chan = 10, remap_err = 0. With E = 25: f = 50, k′ = 5 → chan = 20.
- afh_en = 1, afh_N = 15 → chan = unmapped f, remap_err = 1. afh_N = 30 with 20 used channels and f unused → chan = f, remap_err = 1 after the full scan.
- Second `start_p` while busy → ignored, a single valid pulse only. `rst` asserted during SCAN → IDLE, chan = 0, no pulse.
